// File: rtl/chip8_cpu.sv
// CHIP-8 instruction decoder/executor: turns opcode + stage into per-stage datapath controls.
// Combinational outputs; only vx_q/vy_q are registered (operands latched at stage 2).
package chip8_pkg;
  typedef enum logic [1:0] {
    PC_SRC_NEXT = 2'd0,
    PC_SRC_SKIP = 2'd1,
    PC_SRC_JUMP = 2'd2,
    PC_SRC_POP  = 2'd3
  } PC_SRC;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } Chip8_STATE;
endpackage

module chip8_cpu
  import chip8_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic [15:0] instruction,
  input  logic [31:0] stage,
  input  Chip8_STATE  top_level_state,
  input  logic [7:0]  reg_readdata1,
  input  logic [7:0]  reg_readdata2,
  input  logic [7:0]  mem_readdata1,
  input  logic [7:0]  mem_readdata2,
  input  logic [15:0] reg_I_readdata,
  input  logic [7:0]  delay_timer_readdata,
  input  logic [11:0] PC_readdata,
  input  logic        key_pressed,
  input  logic [3:0]  key_press,
  input  logic        fb_readdata,
  output logic        delay_timer_WE,
  output logic        sound_timer_WE,
  output logic [7:0]  delay_timer_writedata,
  output logic [7:0]  sound_timer_writedata,
  output PC_SRC       pc_src,
  output logic [11:0] PC_writedata,
  output logic        reg_WE1,
  output logic        reg_WE2,
  output logic [3:0]  reg_addr1,
  output logic [3:0]  reg_addr2,
  output logic [7:0]  reg_writedata1,
  output logic [7:0]  reg_writedata2,
  output logic        mem_WE1,
  output logic        mem_WE2,
  output logic [11:0] mem_addr1,
  output logic [11:0] mem_addr2,
  output logic [7:0]  mem_writedata1,
  output logic [7:0]  mem_writedata2,
  output logic        reg_I_WE,
  output logic [15:0] reg_I_writedata,
  output logic        sp_push,
  output logic        sp_pop,
  output logic [4:0]  fb_addr_y,
  output logic [5:0]  fb_addr_x,
  output logic        fb_writedata,
  output logic        fb_WE,
  output logic        fbreset,
  output logic        halt_for_keypress
);

  logic [7:0]  vx_q, vy_q;
  logic [3:0]  x, y;
  logic [7:0]  kk;
  logic [11:0] nnn;
  logic        s1_2, s2, s3, s_ge2;

  logic [8:0]  alu_sum;
  logic [7:0]  alu_res;
  logic        alu_flag, alu_has_flag, alu_valid;

  logic unused_inputs;
  assign unused_inputs = ^{mem_readdata1, mem_readdata2, PC_readdata, fb_readdata, top_level_state};

  assign x     = instruction[11:8];
  assign y     = instruction[7:4];
  assign kk    = instruction[7:0];
  assign nnn   = instruction[11:0];
  assign s2    = (stage == 32'd2);
  assign s3    = (stage == 32'd3);
  assign s1_2  = (stage == 32'd1) || s2;
  assign s_ge2 = (stage >= 32'd2);

  // Operands are read during stages 1-2 and consumed from these latches at stage 3.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      vx_q <= 8'h00;
      vy_q <= 8'h00;
    end else if (s2) begin
      vx_q <= reg_readdata1;
      vy_q <= reg_readdata2;
    end
  end

  always_comb begin
    alu_sum      = {1'b0, vx_q} + {1'b0, vy_q};
    alu_res      = 8'h00;
    alu_flag     = 1'b0;
    alu_has_flag = 1'b0;
    alu_valid    = 1'b1;
    case (instruction[3:0])
      4'h0: alu_res = vy_q;
      4'h1: alu_res = vx_q | vy_q;
      4'h2: alu_res = vx_q & vy_q;
      4'h3: alu_res = vx_q ^ vy_q;
      4'h4: begin alu_res = alu_sum[7:0];   alu_flag = alu_sum[8];     alu_has_flag = 1'b1; end
      4'h5: begin alu_res = vx_q - vy_q;    alu_flag = (vx_q >= vy_q); alu_has_flag = 1'b1; end
      4'h6: begin alu_res = {1'b0, vx_q[7:1]}; alu_flag = vx_q[0];     alu_has_flag = 1'b1; end
      4'h7: begin alu_res = vy_q - vx_q;    alu_flag = (vy_q >= vx_q); alu_has_flag = 1'b1; end
      4'hE: begin alu_res = {vx_q[6:0], 1'b0}; alu_flag = vx_q[7];     alu_has_flag = 1'b1; end
      default: alu_valid = 1'b0;
    endcase
  end

  always_comb begin
    delay_timer_WE        = 1'b0;
    sound_timer_WE        = 1'b0;
    delay_timer_writedata = 8'h00;
    sound_timer_writedata = 8'h00;
    pc_src                = PC_SRC_NEXT;
    PC_writedata          = 12'h000;
    reg_WE1               = 1'b0;
    reg_WE2               = 1'b0;
    reg_addr1             = 4'h0;
    reg_addr2             = 4'h0;
    reg_writedata1        = 8'h00;
    reg_writedata2        = 8'h00;
    mem_WE1               = 1'b0;
    mem_WE2               = 1'b0;
    mem_addr1             = 12'h000;
    mem_addr2             = 12'h000;
    mem_writedata1        = 8'h00;
    mem_writedata2        = 8'h00;
    reg_I_WE              = 1'b0;
    reg_I_writedata       = 16'h0000;
    sp_push               = 1'b0;
    sp_pop                = 1'b0;
    fb_addr_y             = 5'h00;
    fb_addr_x             = 6'h00;
    fb_writedata          = 1'b0;
    fb_WE                 = 1'b0;
    fbreset               = 1'b0;
    halt_for_keypress     = 1'b0;

    case (instruction[15:12])
      4'h0: if (s2) begin
        if (instruction == 16'h00EE) begin
          sp_pop = 1'b1;
          pc_src = PC_SRC_POP;
        end else if (instruction == 16'h00E0) begin
          fbreset = 1'b1;
        end
      end
      4'h1: if (s2) begin
        pc_src       = PC_SRC_JUMP;
        PC_writedata = nnn;
      end
      4'h2: if (s2) begin
        sp_push      = 1'b1;
        pc_src       = PC_SRC_JUMP;
        PC_writedata = nnn;
      end
      4'h3, 4'h4: begin
        if (s1_2) reg_addr1 = x;
        if (s3 && ((vx_q == kk) == (instruction[15:12] == 4'h3))) pc_src = PC_SRC_SKIP;
      end
      4'h5, 4'h9: if (instruction[3:0] == 4'h0) begin
        if (s1_2) begin
          reg_addr1 = x;
          reg_addr2 = y;
        end
        if (s3 && ((vx_q == vy_q) == (instruction[15:12] == 4'h5))) pc_src = PC_SRC_SKIP;
      end
      4'h6: if (s2) begin
        reg_addr1      = x;
        reg_writedata1 = kk;
        reg_WE1        = 1'b1;
      end
      4'h7: begin
        if (s1_2 || s3) reg_addr1 = x;
        if (s3) begin
          reg_WE1        = 1'b1;
          reg_writedata1 = vx_q + kk;
        end
      end
      4'h8: if (alu_valid) begin
        if (s1_2) begin
          reg_addr1 = x;
          reg_addr2 = y;
        end else if (s3) begin
          reg_addr1      = x;
          reg_WE1        = 1'b1;
          reg_writedata1 = alu_res;
          // The flag goes out on port 2 so it wins over the result when x is F.
          if (alu_has_flag) begin
            reg_addr2      = 4'hF;
            reg_WE2        = 1'b1;
            reg_writedata2 = {7'h00, alu_flag};
          end
        end
      end
      4'hA: if (s2) begin
        reg_I_WE        = 1'b1;
        reg_I_writedata = {4'h0, nnn};
      end
      4'hF: case (kk)
        8'h07: if (s2) begin
          reg_addr1      = x;
          reg_WE1        = 1'b1;
          reg_writedata1 = delay_timer_readdata;
        end
        8'h0A: if (s_ge2) begin
          if (key_pressed) begin
            reg_addr1      = x;
            reg_WE1        = 1'b1;
            reg_writedata1 = {4'h0, key_press};
          end else begin
            halt_for_keypress = 1'b1;
          end
        end
        8'h15, 8'h18, 8'h1E: begin
          if (s1_2) reg_addr1 = x;
          if (s3) begin
            if (kk == 8'h15) begin
              delay_timer_WE        = 1'b1;
              delay_timer_writedata = vx_q;
            end else if (kk == 8'h18) begin
              sound_timer_WE        = 1'b1;
              sound_timer_writedata = vx_q;
            end else begin
              reg_I_WE        = 1'b1;
              reg_I_writedata = reg_I_readdata + {8'h00, vx_q};
            end
          end
        end
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_cpu.sv
// Randomized bench for chip8_cpu: every stage of every instruction is compared against an
// opcode-level reference model that tracks the operands latched at stage 2.
module tb_chip8_cpu;
  import chip8_pkg::*;

  typedef struct packed {
    logic        dt_we, st_we;
    logic [7:0]  dt_wd, st_wd;
    logic [1:0]  pc_src;
    logic [11:0] pc_wd;
    logic        we1, we2;
    logic [3:0]  a1, a2;
    logic [7:0]  wd1, wd2;
    logic        mwe1, mwe2;
    logic [11:0] ma1, ma2;
    logic [7:0]  mwd1, mwd2;
    logic        i_we;
    logic [15:0] i_wd;
    logic        push, pop;
    logic [4:0]  fby;
    logic [5:0]  fbx;
    logic        fbwd, fbwe, fbrst, halt;
  } outs_t;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [31:0] stage = 32'd0;
  Chip8_STATE  top_level_state = ST_FETCH;
  logic [7:0]  reg_readdata1 = 8'h00, reg_readdata2 = 8'h00;
  logic [7:0]  mem_readdata1 = 8'h00, mem_readdata2 = 8'h00;
  logic [15:0] reg_I_readdata = 16'h0000;
  logic [7:0]  delay_timer_readdata = 8'h00;
  logic [11:0] PC_readdata = 12'h000;
  logic        key_pressed = 1'b0;
  logic [3:0]  key_press = 4'h0;
  logic        fb_readdata = 1'b0;

  logic        delay_timer_WE, sound_timer_WE;
  logic [7:0]  delay_timer_writedata, sound_timer_writedata;
  PC_SRC       pc_src;
  logic [11:0] PC_writedata;
  logic        reg_WE1, reg_WE2;
  logic [3:0]  reg_addr1, reg_addr2;
  logic [7:0]  reg_writedata1, reg_writedata2;
  logic        mem_WE1, mem_WE2;
  logic [11:0] mem_addr1, mem_addr2;
  logic [7:0]  mem_writedata1, mem_writedata2;
  logic        reg_I_WE;
  logic [15:0] reg_I_writedata;
  logic        sp_push, sp_pop;
  logic [4:0]  fb_addr_y;
  logic [5:0]  fb_addr_x;
  logic        fb_writedata, fb_WE, fbreset, halt_for_keypress;

  chip8_cpu dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .instruction(instruction), .stage(stage),
    .top_level_state(top_level_state),
    .reg_readdata1(reg_readdata1), .reg_readdata2(reg_readdata2),
    .mem_readdata1(mem_readdata1), .mem_readdata2(mem_readdata2),
    .reg_I_readdata(reg_I_readdata), .delay_timer_readdata(delay_timer_readdata),
    .PC_readdata(PC_readdata), .key_pressed(key_pressed), .key_press(key_press),
    .fb_readdata(fb_readdata),
    .delay_timer_WE(delay_timer_WE), .sound_timer_WE(sound_timer_WE),
    .delay_timer_writedata(delay_timer_writedata), .sound_timer_writedata(sound_timer_writedata),
    .pc_src(pc_src), .PC_writedata(PC_writedata),
    .reg_WE1(reg_WE1), .reg_WE2(reg_WE2), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_writedata1(reg_writedata1), .reg_writedata2(reg_writedata2),
    .mem_WE1(mem_WE1), .mem_WE2(mem_WE2), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_writedata1(mem_writedata1), .mem_writedata2(mem_writedata2),
    .reg_I_WE(reg_I_WE), .reg_I_writedata(reg_I_writedata),
    .sp_push(sp_push), .sp_pop(sp_pop), .fb_addr_y(fb_addr_y), .fb_addr_x(fb_addr_x),
    .fb_writedata(fb_writedata), .fb_WE(fb_WE), .fbreset(fbreset),
    .halt_for_keypress(halt_for_keypress)
  );

  always #5 cpu_clk = ~cpu_clk;

  outs_t got;
  assign got = '{dt_we: delay_timer_WE, st_we: sound_timer_WE,
                 dt_wd: delay_timer_writedata, st_wd: sound_timer_writedata,
                 pc_src: pc_src, pc_wd: PC_writedata,
                 we1: reg_WE1, we2: reg_WE2, a1: reg_addr1, a2: reg_addr2,
                 wd1: reg_writedata1, wd2: reg_writedata2,
                 mwe1: mem_WE1, mwe2: mem_WE2, ma1: mem_addr1, ma2: mem_addr2,
                 mwd1: mem_writedata1, mwd2: mem_writedata2,
                 i_we: reg_I_WE, i_wd: reg_I_writedata, push: sp_push, pop: sp_pop,
                 fby: fb_addr_y, fbx: fb_addr_x, fbwd: fb_writedata, fbwe: fb_WE,
                 fbrst: fbreset, halt: halt_for_keypress};

  int n_vec  = 0;
  int n_miss = 0;
  int cap_x  = 0;  // operand values the bench expects the DUT to hold
  int cap_y  = 0;

  task automatic check_vec(input string tag, input outs_t obs, input outs_t exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written per opcode family with integer arithmetic.
  function automatic outs_t model(input logic [15:0] ins, input int s, input logic kp,
                                  input logic [3:0] kc, input logic [7:0] dt,
                                  input logic [15:0] ird, input int vx, input int vy);
    outs_t o;
    int x, y, kk, nnn, r, f;
    bit ok, hasf;
    o = '0;
    x = int'(ins[11:8]); y = int'(ins[7:4]); kk = int'(ins[7:0]); nnn = int'(ins[11:0]);
    case (ins[15:12])
      4'h0: if (s == 2) begin
        if (ins == 16'h00EE) begin o.pop = 1; o.pc_src = PC_SRC_POP; end
        if (ins == 16'h00E0) o.fbrst = 1;
      end
      4'h1, 4'h2: if (s == 2) begin
        o.pc_src = PC_SRC_JUMP; o.pc_wd = 12'(nnn);
        if (ins[15:12] == 4'h2) o.push = 1;
      end
      4'h3, 4'h4, 4'h5, 4'h9: begin
        ok = (ins[15:12] == 4'h3 || ins[15:12] == 4'h4 || ins[3:0] == 4'h0);
        if (ok && (s == 1 || s == 2)) begin
          o.a1 = 4'(x);
          if (ins[15:12] == 4'h5 || ins[15:12] == 4'h9) o.a2 = 4'(y);
        end
        if (ok && s == 3) begin
          case (ins[15:12])
            4'h3: if (vx == kk) o.pc_src = PC_SRC_SKIP;
            4'h4: if (vx != kk) o.pc_src = PC_SRC_SKIP;
            4'h5: if (vx == vy) o.pc_src = PC_SRC_SKIP;
            default: if (vx != vy) o.pc_src = PC_SRC_SKIP;
          endcase
        end
      end
      4'h6: if (s == 2) begin o.a1 = 4'(x); o.wd1 = 8'(kk); o.we1 = 1; end
      4'h7: begin
        if (s >= 1 && s <= 3) o.a1 = 4'(x);
        if (s == 3) begin o.we1 = 1; o.wd1 = 8'((vx + kk) % 256); end
      end
      4'h8: begin
        ok = 1; hasf = 1; r = 0; f = 0;
        case (ins[3:0])
          4'h0: begin r = vy; hasf = 0; end
          4'h1: begin r = vx | vy; hasf = 0; end
          4'h2: begin r = vx & vy; hasf = 0; end
          4'h3: begin r = vx ^ vy; hasf = 0; end
          4'h4: begin r = vx + vy; f = (r > 255) ? 1 : 0; end
          4'h5: begin r = vx - vy + 256; f = (vx >= vy) ? 1 : 0; end
          4'h6: begin r = vx / 2; f = vx % 2; end
          4'h7: begin r = vy - vx + 256; f = (vy >= vx) ? 1 : 0; end
          4'hE: begin r = vx * 2; f = vx / 128; end
          default: ok = 0;
        endcase
        if (ok && (s == 1 || s == 2)) begin o.a1 = 4'(x); o.a2 = 4'(y); end
        if (ok && s == 3) begin
          o.a1 = 4'(x); o.we1 = 1; o.wd1 = 8'(r % 256);
          if (hasf) begin o.a2 = 4'hF; o.we2 = 1; o.wd2 = 8'(f); end
        end
      end
      4'hA: if (s == 2) begin o.i_we = 1; o.i_wd = 16'(nnn); end
      4'hF: begin
        if (kk == 'h07 && s == 2) begin o.a1 = 4'(x); o.we1 = 1; o.wd1 = dt; end
        if (kk == 'h0A && s >= 2) begin
          if (kp) begin o.a1 = 4'(x); o.we1 = 1; o.wd1 = {4'h0, kc}; end
          else o.halt = 1;
        end
        if (kk == 'h15 || kk == 'h18 || kk == 'h1E) begin
          if (s == 1 || s == 2) o.a1 = 4'(x);
          if (s == 3 && kk == 'h15) begin o.dt_we = 1; o.dt_wd = 8'(vx); end
          if (s == 3 && kk == 'h18) begin o.st_we = 1; o.st_wd = 8'(vx); end
          if (s == 3 && kk == 'h1E) begin o.i_we = 1; o.i_wd = 16'((int'(ird) + vx) % 65536); end
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  // Walks stages 0..4, supplying v1/v2 on the read ports at stage 2.
  task automatic run_instr(input logic [15:0] ins, input logic [7:0] v1, input logic [7:0] v2,
                           input bit mid_reset);
    instruction = ins;
    for (int s = 0; s < 5; s++) begin
      stage                = 32'(s);
      top_level_state      = Chip8_STATE'($urandom_range(0, 3));
      delay_timer_readdata = 8'($urandom);
      reg_I_readdata       = 16'($urandom);
      key_pressed          = 1'($urandom);
      key_press            = 4'($urandom);
      mem_readdata1        = 8'($urandom);
      mem_readdata2        = 8'($urandom);
      PC_readdata          = 12'($urandom);
      fb_readdata          = 1'($urandom);
      reg_readdata1        = (s == 2) ? v1 : 8'($urandom);
      reg_readdata2        = (s == 2) ? v2 : 8'($urandom);
      if (mid_reset && s == 3) begin
        reset_n = 1'b0;
        cap_x = 0;
        cap_y = 0;
      end
      #2;
      check_vec($sformatf("op%h_s%0d", ins, s), got,
                model(ins, s, key_pressed, key_press, delay_timer_readdata, reg_I_readdata,
                      cap_x, cap_y));
      if (mid_reset && s == 3) reset_n = 1'b1;
      @(posedge cpu_clk);
      if (s == 2) begin
        cap_x = int'(v1);
        cap_y = int'(v2);
      end
      #1;
    end
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] op;
    logic [7:0]  fsub [10];
    fsub = '{8'h07, 8'h0A, 8'h15, 8'h18, 8'h1E, 8'h29, 8'h33, 8'h55, 8'h65, 8'h0B};
    op = 16'($urandom);
    case (op[15:12])
      4'h0: if ($urandom_range(0, 3) != 0) op = ($urandom_range(0, 1) == 1) ? 16'h00EE : 16'h00E0;
      4'h5, 4'h9: if ($urandom_range(0, 3) != 0) op[3:0] = 4'h0;
      4'hF: op[7:0] = fsub[$urandom_range(0, 9)];
      default: ;
    endcase
    return op;
  endfunction

  initial begin
    outs_t dflt;
    dflt = '0;
    // Reset state: nothing captured, so 7x05 at stage 3 writes just kk.
    instruction = 16'h7305;
    stage = 32'd3;
    #3;
    check_vec("reset_vx_zero", got, model(16'h7305, 3, 1'b0, 4'h0, 8'h00, 16'h0000, 0, 0));
    stage = 32'd0;
    #1;
    check_vec("reset_stage0_default", got, dflt);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    @(posedge cpu_clk);
    #1;

    // Directed cases from the bring-up plan, each also checked field by field.
    run_instr(16'h61F0, 8'h00, 8'h00, 1'b0);
    run_instr(16'h7E54, 8'h10, 8'h33, 1'b0);
    stage = 32'd3;
    #1;
    check_vec("7E54_s3_replay", got, model(16'h7E54, 3, 1'b0, 4'h0, 8'h00, 16'h0000, 'h10, 'h33));
    if (reg_writedata1 !== 8'h64) begin
      n_miss++;
      $display("FAIL 7E54_wd1: got %h expected 64", reg_writedata1);
    end
    n_vec++;
    run_instr(16'h8124, 8'hF0, 8'h20, 1'b0);
    stage = 32'd3;
    #1;
    check_vec("8124_s3", got, model(16'h8124, 3, 1'b0, 4'h0, 8'h00, 16'h0000, 'hF0, 'h20));
    run_instr(16'h3A05, 8'h05, 8'h00, 1'b0);
    run_instr(16'h3A05, 8'h06, 8'h00, 1'b0);
    run_instr(16'hA123, 8'h00, 8'h00, 1'b0);
    run_instr(16'h2456, 8'h00, 8'h00, 1'b0);
    run_instr(16'h00EE, 8'h00, 8'h00, 1'b0);
    run_instr(16'h8FF5, 8'h10, 8'h20, 1'b0);

    // Fx0A held then released.
    instruction = 16'hF30A;
    stage = 32'd2;
    key_pressed = 1'b0;
    key_press = 4'h7;
    #1;
    check_vec("F30A_halt", got, model(16'hF30A, 2, 1'b0, 4'h7, delay_timer_readdata, reg_I_readdata, cap_x, cap_y));
    key_pressed = 1'b1;
    #1;
    check_vec("F30A_key7", got, model(16'hF30A, 2, 1'b1, 4'h7, delay_timer_readdata, reg_I_readdata, cap_x, cap_y));
    @(posedge cpu_clk);
    cap_x = int'(reg_readdata1);
    cap_y = int'(reg_readdata2);
    #1;

    // Reset mid-instruction must drop the latched operand.
    run_instr(16'h7E54, 8'h10, 8'h00, 1'b1);

    for (int i = 0; i < 400; i++) begin
      run_instr(rand_op(), 8'($urandom), 8'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/chip8_cpu.md
Name: chip8_cpu

Overview:
- Combinational instruction decoder/executor of the CHIP-8 core.
- Inputs: the current 16-bit opcode and an externally supplied stage counter.
- Outputs: per-stage control and data for the register file, I register, PC/stack, timers, frame buffer and memory.
- Sits between the top-level sequencer (owns fetch, stage counter and state) and the datapath blocks.

Parameters:
- none

Ports:
- cpu_clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- instruction  in  16  current opcode, stable for the whole instruction
- stage  in  32  stage counter; 0 at instruction start, +1 per cpu_clk rising edge
- top_level_state  in  Chip8_STATE  reserved; no effect
- reg_readdata1/2  in  8 each  register file read data, ports 1/2
- mem_readdata1/2  in  8 each  memory read data (unused)
- reg_I_readdata  in  16  I register value
- delay_timer_readdata  in  8  delay timer value
- PC_readdata  in  12  PC value (unused)
- key_pressed  in  1  a key is held
- key_press  in  4  code of the held key
- fb_readdata  in  1  frame buffer read (unused)
- delay_timer_WE, sound_timer_WE  out  1 each  timer write enables
- delay_timer_writedata, sound_timer_writedata  out  8 each  timer write data
- pc_src  out  PC_SRC  PC next-value select
- PC_writedata  out  12  jump/call target
- reg_WE1/2  out  1 each  register write enables
- reg_addr1/2  out  4 each  register addresses
- reg_writedata1/2  out  8 each  register write data
- mem_WE1/2  out  1 each  memory write enables
- mem_addr1/2  out  12 each  memory addresses
- mem_writedata1/2  out  8 each  memory write data
- reg_I_WE  out  1  I write enable
- reg_I_writedata  out  16  I write data
- sp_push, sp_pop  out  1 each  stack push/pop strobes
- fb_addr_y  out  5  frame buffer row
- fb_addr_x  out  6  frame buffer column
- fb_writedata, fb_WE, fbreset  out  1 each  frame buffer data, write enable, clear
- halt_for_keypress  out  1  request the sequencer to stall

Behaviour:
- Outputs are purely combinational from instruction, stage and the readdata inputs; they are valid ~1 ns after a stage change.
- Default, driven whenever no rule below applies (including stage 0 and every stage after an opcode's last active stage): all enables, strobes, addresses and data 0; pc_src = PC_SRC_NEXT.
- Field names: x = instr[11:8], y = instr[7:4], kk = instr[7:0], nnn = instr[11:0].
- Internal registers: vx_q and vy_q (8-bit) capture reg_readdata1/2 on the cpu_clk rising edge while stage==2; cleared asynchronously when reset_n = 0. Reset forces no other output state.
- 6xkk, stage 2: reg_addr1 = x, reg_writedata1 = kk, reg_WE1 = 1.
- 7xkk:
  - Stages 1–3: reg_addr1 = x.
  - Stage 3: reg_WE1 = 1, reg_writedata1 = (vx_q + kk) mod 256. VF is untouched.
- 8xyN:
  - Stages 1–2: reg_addr1 = x, reg_addr2 = y.
  - Stage 3: reg_addr1 = x, reg_WE1 = 1, reg_writedata1 = result.
  - Results: N=0 Vy; 1 OR; 2 AND; 3 XOR; 4 add; 5 Vx−Vy; 6 Vx>>1; 7 Vy−Vx; E Vx<<1. All mod 256.
  - For N = 4/5/6/7/E, stage 3 also drives reg_addr2 = F, reg_WE2 = 1, reg_writedata2 = flag.
  - Flags: 4 carry; 5 (Vx ≥ Vy); 6 Vx[0]; 7 (Vy ≥ Vx); E Vx[7].
  - When x = F, both ports target VF; the flag is on port 2.
  - Other N values: defaults.
- 3xkk / 4xkk / 5xy0 / 9xy0:
  - Stages 1–2: reg_addr1 = x; reg_addr2 = y for 5xy0 and 9xy0.
  - Stage 3: pc_src = PC_SRC_SKIP when the condition holds (3: Vx == kk; 4: Vx != kk; 5: Vx == Vy; 9: Vx != Vy).
- Annn, stage 2: reg_I_WE = 1, reg_I_writedata = {4'h0, nnn}.
- 1nnn, stage 2: pc_src = PC_SRC_JUMP, PC_writedata = nnn.
- 2nnn, stage 2: sp_push = 1, pc_src = PC_SRC_JUMP, PC_writedata = nnn.
- 00EE, stage 2: sp_pop = 1, pc_src = PC_SRC_POP.
- 00E0, stage 2: fbreset = 1.
- Fx07, stage 2: reg_addr1 = x, reg_WE1 = 1, reg_writedata1 = delay_timer_readdata.
- Fx15 / Fx18 / Fx1E:
  - Stages 1–2: reg_addr1 = x.
  - Stage 3, Fx15: delay_timer_WE = 1, delay_timer_writedata = vx_q.
  - Stage 3, Fx18: sound_timer_WE = 1, sound_timer_writedata = vx_q.
  - Stage 3, Fx1E: reg_I_WE = 1, reg_I_writedata = reg_I_readdata + vx_q (16-bit wrap).
- Fx0A:
  - Stage ≥ 2 with key_pressed = 0: halt_for_keypress = 1 (the sequencer holds the stage).
  - Stage ≥ 2 with key_pressed = 1: halt_for_keypress = 0, reg_addr1 = x, reg_WE1 = 1, reg_writedata1 = {4'h0, key_press}.
- All other opcodes (Bnnn, Cxkk, Dxyn, Exxx, Fx29, Fx33, Fx55, Fx65, unknown): defaults at every stage.
- Memory and frame-buffer address/data ports stay 0 in all cases.

Test Plan:
- 61F0, stage 2 → reg_addr1 = 1, reg_writedata1 = F0, reg_WE1 = 1. Stage 3 → every output at default.
- 7E54 with reg_readdata1 = 10 captured at stage 2:
  - Stage 2 → reg_addr1 = E.
  - Stage 3 → reg_addr1 = E, reg_WE1 = 1, writedata1 = 64.
  - Stage 4 → all defaults.
- 8124 with V1 = F0, V2 = 20, stage 3 → writedata1 = 10; reg_addr2 = F, reg_WE2 = 1, writedata2 = 01.
- 3A05 with VA = 05 → stage 3 pc_src = PC_SRC_SKIP. With VA = 06 → pc_src = PC_SRC_NEXT.
- A123 and 2456, stage 2:
  - A123 → reg_I_WE = 1, reg_I_writedata = 0123.
  - 2456 → sp_push = 1, PC_writedata = 456, pc_src = PC_SRC_JUMP.
- F30A, stage 2:
  - key_pressed = 0 → halt_for_keypress = 1.
  - Raise key_pressed with key_press = 7 → halt_for_keypress = 0, reg_addr1 = 3, reg_WE1 = 1, writedata1 = 07.
  - Assert reset_n low mid-instruction → vx_q clears.
